ssd_scan_ctrl: RTL and testbench
================================

// Module: ssd_scan_ctrl
// PURPOSE
//  Parametrised multiplexed seven-segment scanner; successor to the fixed 4-digit counter + 74HC138 driver.
//  Cycles a one-hot digit common across DIGITS digits at a prescaled refresh rate.
//  Decodes a per-digit hex nibble to segments, with an optional inter-digit blanking gap (anti-ghosting).
//  Adds a per-digit mask, decimal points and a frame-sync pulse. Sits between the datapath and the board pins.
// PARAMETERS
//  DIGITS          4      number of digits scanned, 2..8
//  PRESCALE        50000  Clk cycles per tick, >=1
//  BLANK_TICKS     1      ticks of all-off gap after each digit slot, 0..15
//  COM_ACTIVE_LOW  1      1: selected COM driven 0, others 1; 0: inverted
//  SEG_ACTIVE_LOW  0      1: lit segment/dp driven 0; 0: lit driven 1
// PORTS
//  Clk       in   1          system clock, rising edge
//  Aclr      in   1          asynchronous reset, active-high
//  en_i      in   1          scan enable
//  digits_i  in   4*DIGITS   hex nibbles; digit k at [4k+3:4k], digit 0 = rightmost
//  dp_i      in   DIGITS     decimal point request per digit
//  mask_i    in   DIGITS     1 = digit may light; 0 = slot kept but dark
//  com_o     out  DIGITS     digit commons, polarity per COM_ACTIVE_LOW
//  seg_o     out  7          segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  dp_o      out  1          decimal point, polarity per SEG_ACTIVE_LOW
//  frame_o   out  1          one-cycle pulse at start of each scan frame
// BEHAVIOUR
//  Reset (Aclr=1, async):
//   - state OFF, idx=0, prescaler=0, gap count=0, frame_o=0.
//   - All COM inactive; seg_o and dp_o unlit.
//  Outputs are registered and update on the same edge as state/idx.
//  Prescaler:
//   - Runs only in SHOW/GAP; counts 0..PRESCALE-1.
//   - tick is high when count==PRESCALE-1, and count wraps to 0.
//   - Prescaler is cleared to 0 on every state entry.
//  FSM states:
//   - OFF: all dark. en_i=1 at edge k -> SHOW, idx=0, frame_o=1 after edge k.
//   - SHOW: com_o[idx] active if mask_i[idx] (and not LZB-blanked); seg_o=hex(nibble); dp_o=dp_i[idx].
//     Each slot lasts exactly PRESCALE cycles.
//     On tick: BLANK_TICKS==0 -> SHOW with idx+1; else -> GAP.
//   - GAP: all COM inactive; seg/dp unlit; lasts BLANK_TICKS*PRESCALE cycles, then SHOW with idx+1.
//  Index advance:
//   - idx wraps DIGITS-1 -> 0.
//   - frame_o=1 for exactly the first cycle of each idx-0 SHOW.
//  Nibble, dp and mask are sampled at SHOW entry and held for the whole slot; input changes mid-slot are ignored.
//  en_i=0 in any state -> OFF on next edge, idx=0; re-enable always restarts at digit 0.
//  Frame period = DIGITS*(1+BLANK_TICKS)*PRESCALE cycles.
//  Hex decode {g..a}, active-high form:
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//  A masked digit occupies its slot dark (uniform brightness); the slot timing is unchanged.
//  PRESCALE=1 ticks every cycle: each slot is 1 cycle, and each gap is BLANK_TICKS cycles.
// CONFIGURATION
//  SSD_LEAD_ZERO_BLANK_EN defined:
//   - Leading-zero blanking. Digits from DIGITS-1 downward whose nibble is 0, up to the first nonzero, are dark.
//   - Evaluated on the live digits_i at each SHOW entry; digit 0 is never blanked.
//   - dp_i[idx]=1 forces the digit lit.
//  Undefined: every unmasked digit lights, zeros included.
// TESTING (DIGITS=4, PRESCALE=4, BLANK_TICKS=1, COM_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0 unless noted)
//  1. Reset and enable:
//     - Aclr=1 -> com_o=4'hF, seg_o=7'h00, dp_o=0, frame_o=0.
//     - Release Aclr, en_i=1 -> com_o=4'hE one cycle later.
//  2. digits_i=16'h1234, mask_i=4'hF, dp_i=0:
//     - com_o=4'hE, seg_o=7'h66 for 4 cycles; then 4'hF, 7'h00 for 4 cycles; then 4'hD, 7'h4F.
//     - frame_o pulses every 32 cycles.
//  3. BLANK_TICKS=0, digits_i=16'hF000:
//     - com_o steps E,D,B,7 every 4 cycles with no gap.
//     - digit 3 shows seg_o=7'h71; frame period 16 cycles.
//  4. mask_i=4'b1011 -> the digit-2 slot shows com_o=4'hF for its 4 cycles; period still 32.
//     Then drop en_i during digit-1 SHOW -> all dark next cycle; re-enable -> digit 0 first, frame_o=1.
//  5. Change digits_i mid-slot -> seg_o holds until the next slot.
//     Pulse Aclr mid-GAP -> immediately dark, idx=0.
//  6. digits_i=16'h0050:
//     - With SSD_LEAD_ZERO_BLANK_EN, digits 3 and 2 are dark, digit 1 shows 7'h6D, digit 0 shows 7'h3F.
//     - Without the macro, all four light.
//     - Repeat with SEG_ACTIVE_LOW=1 and COM_ACTIVE_LOW=0: every output is bitwise inverted.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// ssd_scan_ctrl
//   Multiplexed seven-segment scanner. Steps a one-hot digit common across
//   DIGITS digits at a prescaled refresh rate and decodes that digit's hex
//   nibble to segments. An optional all-off gap after each digit slot
//   suppresses ghosting. Also provides a per-digit mask, decimal points and a
//   frame-sync pulse.
//
//   Optional feature: define SSD_LEAD_ZERO_BLANK_EN to enable leading-zero
//   blanking. Leading zero digits, counted from DIGITS-1 downward, are kept
//   dark. Digit 0 is never blanked, and a set decimal point keeps a digit lit.
//
// Ports
//   Clk       in   1         system clock, rising edge
//   Aclr      in   1         asynchronous reset, active-high
//   en_i      in   1         scan enable; low returns to OFF at digit 0
//   digits_i  in   4*DIGITS  hex nibbles, digit k at [4k+3:4k], digit 0 rightmost
//   dp_i      in   DIGITS    decimal point request per digit
//   mask_i    in   DIGITS    1 = digit may light, 0 = slot kept but dark
//   com_o     out  DIGITS    digit commons, polarity per COM_ACTIVE_LOW
//   seg_o     out  7         segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp_o      out  1         decimal point, polarity per SEG_ACTIVE_LOW
//   frame_o   out  1         one-cycle pulse in the first cycle of each frame
// -----------------------------------------------------------------------------
module ssd_scan_ctrl #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_TICKS    = 1,
    parameter int COM_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  Clk,
    input  logic                  Aclr,
    input  logic                  en_i,
    input  logic [4*DIGITS-1:0]   digits_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     mask_i,
    output logic [DIGITS-1:0]     com_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [3:0]    GAP_LAST   = (BLANK_TICKS > 0) ? 4'(BLANK_TICKS - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      gap_q, gap_d;
    // Output registers hold the active-high "lit" view; polarity is applied at the pins.
    logic [DIGITS-1:0] com_q, com_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              frame_q, frame_d;

    logic            tick;
    logic [IW-1:0]   idx_next;
    logic            enter_show;
    logic [IW-1:0]   show_idx;
    logic            blank;
    logic            lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign tick     = (presc_q == PRESC_LAST);
    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

`ifdef SSD_LEAD_ZERO_BLANK_EN
    // lead_zero[k] is set when digit k and every digit above it are zero.
    logic [DIGITS-1:0] lead_zero;
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run          = run && (digits_i[4*k +: 4] == 4'h0);
            lead_zero[k] = run;
        end
    end
    assign blank = lead_zero[show_idx] && (show_idx != '0) && !dp_i[show_idx];
`else
    assign blank = 1'b0;
`endif

    assign lit = mask_i[show_idx] && !blank;

    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        presc_d    = presc_q;
        gap_d      = gap_q;
        com_d      = com_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        frame_d    = 1'b0;
        enter_show = 1'b0;
        show_idx   = idx_q;

        if (!en_i) begin
            state_d = ST_OFF;
            idx_d   = '0;
            presc_d = '0;
            gap_d   = '0;
            com_d   = '0;
            seg_d   = '0;
            dp_d    = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    enter_show = 1'b1;
                    show_idx   = '0;
                end
                ST_SHOW: begin
                    if (tick) begin
                        if (BLANK_TICKS == 0) begin
                            enter_show = 1'b1;
                            show_idx   = idx_next;
                        end else begin
                            state_d = ST_GAP;
                            presc_d = '0;
                            gap_d   = '0;
                            com_d   = '0;
                            seg_d   = '0;
                            dp_d    = 1'b0;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_q == GAP_LAST) begin
                            enter_show = 1'b1;
                            show_idx   = idx_next;
                        end else begin
                            gap_d   = gap_q + 4'd1;
                            presc_d = '0;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    presc_d = '0;
                    gap_d   = '0;
                end
            endcase
        end

        // Inputs are sampled only here, so the registered outputs hold for the slot.
        if (enter_show) begin
            state_d         = ST_SHOW;
            idx_d           = show_idx;
            presc_d         = '0;
            gap_d           = '0;
            com_d           = '0;
            com_d[show_idx] = lit;
            seg_d           = hex_to_seg(digits_i[4*show_idx +: 4]);
            dp_d            = dp_i[show_idx];
            frame_d         = (show_idx == '0);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge Clk or posedge Aclr) begin
        if (Aclr) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            presc_q <= '0;
            gap_q   <= '0;
            com_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            gap_q   <= gap_d;
            com_q   <= com_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign com_o   = (COM_ACTIVE_LOW != 0) ? ~com_q : com_q;
    assign seg_o   = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp_o    = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan_ctrl
//   Three scanner instances share one stimulus: dut_a is the default build
//   (4 digits, prescale 4, one blank tick), dut_b has no blanking gap, and
//   dut_c has both output polarities inverted. Each phase resets all three and
//   observes one instance. The expected per-cycle outputs are queued as the
//   stimulus is set and popped on each falling edge.
// -----------------------------------------------------------------------------
module tb_ssd_scan_ctrl;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        aclr;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  mask;

    logic [3:0] com_a, com_b, com_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic       fr_a, fr_b, fr_c;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.DIGITS(4), .PRESCALE(P), .BLANK_TICKS(1),
                    .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) dut_a (
        .Clk(clk), .Aclr(aclr), .en_i(en), .digits_i(digits), .dp_i(dp),
        .mask_i(mask), .com_o(com_a), .seg_o(seg_a), .dp_o(dp_a), .frame_o(fr_a));

    ssd_scan_ctrl #(.DIGITS(4), .PRESCALE(P), .BLANK_TICKS(0),
                    .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) dut_b (
        .Clk(clk), .Aclr(aclr), .en_i(en), .digits_i(digits), .dp_i(dp),
        .mask_i(mask), .com_o(com_b), .seg_o(seg_b), .dp_o(dp_b), .frame_o(fr_b));

    ssd_scan_ctrl #(.DIGITS(4), .PRESCALE(P), .BLANK_TICKS(1),
                    .COM_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)) dut_c (
        .Clk(clk), .Aclr(aclr), .en_i(en), .digits_i(digits), .dp_i(dp),
        .mask_i(mask), .com_o(com_c), .seg_o(seg_c), .dp_o(dp_c), .frame_o(fr_c));

    int checks   = 0;
    int failures = 0;

    // Expected output word: {frame, dp, seg[6:0], com[3:0]}
    logic [12:0] exp_q[$];

    int sel;       // 0 = dut_a, 1 = dut_b, 2 = dut_c
    int bt;        // blank ticks of the observed instance
    bit com_low;
    bit seg_low;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] observe();
        case (sel)
            0:       observe = {fr_a, dp_a, seg_a, com_a};
            1:       observe = {fr_b, dp_b, seg_b, com_b};
            default: observe = {fr_c, dp_c, seg_c, com_c};
        endcase
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    function automatic bit lzb_blank(input int k);
`ifdef SSD_LEAD_ZERO_BLANK_EN
        if (k == 0 || dp[k]) return 1'b0;
        for (int j = k; j < 4; j++)
            if (digits[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return (k < 0);
`endif
    endfunction

    function automatic logic [12:0] dark_word();
        logic [3:0] c;
        logic [6:0] s;
        logic       d;
        c = com_low ? 4'hF : 4'h0;
        s = seg_low ? 7'h7F : 7'h00;
        d = seg_low;
        return {1'b0, d, s, c};
    endfunction

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(dark_word());
    endtask

    task automatic push_show(input int idx, input logic [3:0] nib, input bit d,
                             input bit lit, input int n);
        logic [3:0] c;
        logic [6:0] s;
        logic       db;
        c  = lit ? (4'b0001 << idx) : 4'b0000;
        s  = hex7(nib);
        db = d;
        if (com_low) c = ~c;
        if (seg_low) begin
            s  = ~s;
            db = ~db;
        end
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == 0 && idx == 0), db, s, c});
    endtask

    task automatic push_digit(input int idx);
        push_show(idx, digits[4*idx +: 4], dp[idx], mask[idx] && !lzb_blank(idx), P);
        push_dark(bt * P);
    endtask

    task automatic push_frame();
        for (int i = 0; i < 4; i++) push_digit(i);
    endtask

    task automatic drain(input string tag, input int n);
        logic [12:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check(tag, observe(), e);
        end
    endtask

    task automatic drain_all(input string tag);
        drain(tag, exp_q.size());
    endtask

    // Reset everything, check the observed instance is dark, then enable.
    task automatic start_phase(input string tag, input int s, input int b,
                               input bit cl, input bit sl);
        sel     = s;
        bt      = b;
        com_low = cl;
        seg_low = sl;
        exp_q.delete();
        aclr = 1'b1;
        en   = 1'b0;
        @(negedge clk);
        check({tag, "_reset"}, observe(), dark_word());
        aclr = 1'b0;
        en   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aclr   = 1'b1;
        en     = 1'b0;
        digits = 16'h0000;
        dp     = 4'h0;
        mask   = 4'hF;
        sel    = 0;
        bt     = 1;
        com_low = 1'b1;
        seg_low = 1'b0;

        // Basic scan with gaps; one frame plus the next digit-0 slot.
        digits = 16'h1234; mask = 4'hF; dp = 4'h0;
        start_phase("p1", 0, 1, 1'b1, 1'b0);
        push_frame();
        push_show(0, digits[3:0], dp[0], 1'b1, P);
        drain_all("p1_scan");

        // Masked digit 2, then drop enable mid digit-1 slot and re-enable.
        digits = 16'h1234; mask = 4'b1011; dp = 4'b0001;
        start_phase("p2", 0, 1, 1'b1, 1'b0);
        push_frame();
        push_digit(0);
        push_show(1, digits[7:4], dp[1], mask[1] && !lzb_blank(1), 2);
        drain_all("p2_mask");
        en = 1'b0;
        push_dark(3);
        drain_all("p2_off");
        en = 1'b1;
        push_show(0, digits[3:0], dp[0], mask[0], P);
        drain_all("p2_restart");

        // Mid-slot input change is ignored; async clear mid-gap.
        digits = 16'h1234; mask = 4'hF; dp = 4'h0;
        start_phase("p3", 0, 1, 1'b1, 1'b0);
        push_show(0, 4'h4, 1'b0, 1'b1, P);
        drain("p3_hold", 2);
        digits = 16'hABCD;
        drain_all("p3_hold");
        push_dark(P);
        push_show(1, digits[7:4], dp[1], 1'b1, P);
        push_dark(2);
        drain_all("p3_next");
        aclr = 1'b1;
        #1;
        check("p3_async_clr", observe(), dark_word());
        @(negedge clk);
        aclr = 1'b0;
        push_show(0, digits[3:0], dp[0], 1'b1, P);
        drain_all("p3_after_clr");

        // No blanking gap: 16-cycle frame.
        digits = 16'hF000; mask = 4'hF; dp = 4'h0;
        start_phase("p4", 1, 0, 1'b1, 1'b0);
        push_frame();
        push_show(0, digits[3:0], dp[0], 1'b1, P);
        drain_all("p4_nogap");

        // Leading zeros (blanked only when the feature is built in).
        digits = 16'h0050; mask = 4'hF; dp = 4'h0;
        start_phase("p5", 0, 1, 1'b1, 1'b0);
        push_frame();
        push_show(0, digits[3:0], dp[0], 1'b1, P);
        drain_all("p5_lzb");

        // Same pattern on the inverted-polarity instance.
        start_phase("p6", 2, 1, 1'b0, 1'b1);
        push_frame();
        push_show(0, digits[3:0], dp[0], 1'b1, P);
        drain_all("p6_inv");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
